sub_serial: RTL

//  Bit-serial subtractor; the inverse-operation companion of the serial adder in the datapath.

---
 rtl/sub_serial_pkg.sv | 10 +
 rtl/sub_serial_fs.sv | 13 +
 rtl/sub_serial.sv | 98 +++++++++
 3 files changed

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the serial arithmetic blocks (subtractor now, adder later).
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_serial_fs.sv
// Combinational one-bit full subtractor: x - y - bin -> difference d, borrow-out bout.
module serial_fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: captures a and b, produces a - b LSB-first through one
// full-subtractor cell, then holds the parallel difference and final borrow.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             d_bit, bout_bit;

  serial_fs u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    case (state_q)
      IDLE, DONE: begin
        if (en) begin
          a_d     = a;
          b_d     = b;
          out_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        out_d = {d_bit, out_q[WIDTH-1:1]};
        brw_d = bout_bit;
        // Counter parks at zero on the last bit so it never exceeds WIDTH-1.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out    = out_q;
  assign borrow = brw_q;
  assign busy   = (state_q == SUB);
  assign done   = (state_q == DONE);

endmodule
